// File: rtl/cnt_arb_pkg.sv
// Shared types and default sizing for the slot-counter arbiter.
package cnt_arb_pkg;

  localparam int DEF_CNT_W   = 3;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/slot_counter.sv
// CNT_W-bit slot counter with enable, synchronous clear and async active-low reset.
module slot_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  // Clear has priority so a slot end and a new grant both restart from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cnt_slot_arbiter.sv
// Round-robin arbiter granting timed slots of one shared counter.
// Optional macro CNT_SLOT_ARB_PRIO_EN makes requester 0 a fixed high-priority requester.
module cnt_slot_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] slot_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [IDW-1:0]           gnt_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt,
  output logic [NUM_REQ-1:0]       done
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]       gntId_q, gntId_d;
  logic [CNT_W-1:0]     len_q, len_d;

  logic [IDW-1:0]       winner;
  logic                 winValid;
  logic                 lastCycle;
  logic                 cntEn;
  logic                 cntClr;
  logic [CNT_W-1:0]     cntVal;
  int unsigned          idx;

  slot_counter #(
    .CNT_W(CNT_W)
  ) u_slot_counter (
    .clk (clk),
    .rst (rst),
    .en  (cntEn),
    .clr (cntClr),
    .cnt (cntVal)
  );

  // Rotating search from ptr; the first requester found wins.
  always_comb begin
    winner   = '0;
    winValid = 1'b0;
    idx      = 0;
`ifdef CNT_SLOT_ARB_PRIO_EN
    if (req[0]) begin
      winValid = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!winValid && req[idx]) begin
        winner   = IDW'(idx);
        winValid = 1'b1;
      end
    end
  end

  // len_q - 1 wraps to all-ones for L=0, giving the full 2**CNT_W cycle slot.
  assign lastCycle = (state_q == RUN) && (cntVal == len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    gntId_d = gntId_q;
    len_d   = len_q;
    cntEn   = 1'b0;
    cntClr  = 1'b0;
    case (state_q)
      IDLE: begin
        cntClr = 1'b1;
        if (winValid) begin
          state_d = RUN;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          gntId_d = winner;
          len_d   = slot_len[winner*CNT_W +: CNT_W];
`ifdef CNT_SLOT_ARB_PRIO_EN
          if (!req[0]) begin
            ptr_d = (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
          end
`else
          ptr_d = (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
`endif
        end
      end
      RUN: begin
        if (lastCycle || !req[gntId_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          gntId_d = '0;
          cntClr  = 1'b1;
        end else begin
          cntEn = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        gntId_d = '0;
        cntClr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      gntId_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      gntId_q <= gntId_d;
      len_q   <= len_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gntId_q;
  assign busy   = (state_q == RUN);
  assign cnt    = cntVal;
  assign done   = lastCycle ? gnt_q : '0;

endmodule

// File: tb/tb_cnt_slot_arbiter.sv
// Directed self-checking bench for cnt_slot_arbiter (NUM_REQ=4, CNT_W=3).
module tb_cnt_slot_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] slot_len;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [2:0]  cnt;
  logic [3:0]  done;

  int assertCount = 0;
  int failCount   = 0;

  cnt_slot_arbiter #(
    .NUM_REQ(4),
    .CNT_W  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .slot_len (slot_len),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .cnt      (cnt),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqVal, input logic [2:0] l3, input logic [2:0] l2,
                               input logic [2:0] l1, input logic [2:0] l0);
    req      = reqVal;
    slot_len = {l3, l2, l1, l0};
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [3:0] eGnt, input logic [1:0] eId,
                          input logic eBusy, input logic [2:0] eCnt, input logic [3:0] eDone);
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(eGnt));
    checkOutput({tag, ".gnt_id"}, 32'(gnt_id), 32'(eId));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(eBusy));
    checkOutput({tag, ".cnt"}, 32'(cnt), 32'(eCnt));
    checkOutput({tag, ".done"}, 32'(done), 32'(eDone));
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    tick();
    checkAll("reset", 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);
    rst = 1'b1;
    tick();
    checkAll("idle", 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);

    // Single request, len0=3
    applyStimulus(4'b0001, 3'd0, 3'd0, 3'd0, 3'd3);
    tick();
    checkAll("single.c0", 4'b0001, 2'd0, 1'b1, 3'd0, 4'b0000);
    tick();
    checkAll("single.c1", 4'b0001, 2'd0, 1'b1, 3'd1, 4'b0000);
    tick();
    checkAll("single.c2", 4'b0001, 2'd0, 1'b1, 3'd2, 4'b0001);
    req = 4'b0000;
    tick();
    checkAll("single.end", 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);

    // Round-robin with all lengths 1; pointer sits at 1 after the single grant
    applyStimulus(4'b1111, 3'd1, 3'd1, 3'd1, 3'd1);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] eId;
      logic [3:0] eGnt;
      eId  = 2'((1 + i) % 4);
      eGnt = 4'b0001 << eId;
      tick();
      checkAll($sformatf("rr%0d", i), eGnt, eId, 1'b1, 3'd0, eGnt);
      if (i == 4) req = 4'b0000;
      tick();
      checkAll($sformatf("rr%0d.gap", i), 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);
    end

    // Max length: len2=0 runs 8 cycles
    applyStimulus(4'b0100, 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    for (int c = 0; c < 8; c++) begin
      checkAll($sformatf("max.c%0d", c), 4'b0100, 2'd2, 1'b1, 3'(c), (c == 7) ? 4'b0100 : 4'b0000);
      if (c == 7) req = 4'b0000;
      tick();
    end
    checkAll("max.end", 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);

    // Early release: len1=5, drop at cnt=2
    applyStimulus(4'b0010, 3'd0, 3'd0, 3'd5, 3'd0);
    tick();
    checkAll("early.c0", 4'b0010, 2'd1, 1'b1, 3'd0, 4'b0000);
    tick();
    tick();
    checkAll("early.c2", 4'b0010, 2'd1, 1'b1, 3'd2, 4'b0000);
    req = 4'b0000;
    checkOutput("early.drop.done", 32'(done), 32'd0);
    tick();
    checkAll("early.end", 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);

    // Pointer now at 2: requesters 0,1,2 pending, 2 must win; len2=6
    applyStimulus(4'b0111, 3'd0, 3'd6, 3'd1, 3'd1);
    tick();
    checkAll("after.early", 4'b0100, 2'd2, 1'b1, 3'd0, 4'b0000);
    tick();
    tick();
    tick();
    tick();
    checkAll("rstmid.c4", 4'b0100, 2'd2, 1'b1, 3'd4, 4'b0000);
    rst = 1'b0;
    #1;
    checkAll("rstmid.async", 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);
    applyStimulus(4'b1111, 3'd2, 3'd2, 3'd2, 3'd2);
    tick();
    checkAll("rstmid.held", 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);
    rst = 1'b1;
    tick();
    checkAll("rstrel.c0", 4'b0001, 2'd0, 1'b1, 3'd0, 4'b0000);
    tick();
    checkAll("rstrel.c1", 4'b0001, 2'd0, 1'b1, 3'd1, 4'b0001);
    req = 4'b0000;
    tick();
    checkAll("rstrel.end", 4'b0000, 2'd0, 1'b0, 3'd0, 4'b0000);

`ifdef CNT_SLOT_ARB_PRIO_EN
    // Requester 0 always wins; pointer stays at 0 across its grants
    applyStimulus(4'b1111, 3'd1, 3'd1, 3'd1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll($sformatf("prio0.%0d", i), 4'b0001, 2'd0, 1'b1, 3'd0, 4'b0001);
      if (i == 2) req = 4'b1110;
      tick();
      checkOutput($sformatf("prio0.gap%0d", i), 32'(gnt), 32'd0);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      checkAll($sformatf("prioRot.%0d", i), 4'b0001 << i, 2'(i), 1'b1, 3'd0, 4'b0001 << i);
      if (i == 3) req = 4'b0000;
      tick();
      checkOutput($sformatf("prioRot.gap%0d", i), 32'(gnt), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
